// File: rtl/pipe_execute_stage.sv
// ============================================================================
// Module   : pipe_execute_stage
// Brief    : ID/EX pipeline register plus ALU, zero flag and branch target.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_execute_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] id_imm,
   input  logic [31:0] id_a_in,
   input  logic [31:0] id_b_in,
   input  logic        id_wreg,
   input  logic        id_m2reg,
   input  logic        id_wmem,
   input  logic [5:0]  id_aluc,
   input  logic        id_aluimm,
   input  logic        id_shift,
   input  logic        id_branch,
   input  logic [31:0] id_pc4,
   input  logic [4:0]  id_destR,
   input  logic [3:0]  ex_ins_type,
   input  logic [3:0]  ex_ins_number,
   output logic        ex_wreg,
   output logic        ex_m2reg,
   output logic        ex_wmem,
   output logic        ex_branch,
   output logic [31:0] ex_aluR,
   output logic [31:0] ex_inB,
   output logic [4:0]  ex_destR,
   output logic [31:0] ex_pc,
   output logic        ex_zero,
   output logic [3:0]  mem_ins_type,
   output logic [3:0]  mem_ins_number,
   output logic        led,
   output logic [31:0] dbg
);

   localparam logic [5:0] c_op_add  = 6'd0;
   localparam logic [5:0] c_op_sub  = 6'd1;
   localparam logic [5:0] c_op_and  = 6'd2;
   localparam logic [5:0] c_op_or   = 6'd3;
   localparam logic [5:0] c_op_xor  = 6'd4;
   localparam logic [5:0] c_op_nor  = 6'd5;
   localparam logic [5:0] c_op_slt  = 6'd6;
   localparam logic [5:0] c_op_sll  = 6'd7;
   localparam logic [5:0] c_op_srl  = 6'd8;
   localparam logic [5:0] c_op_sra  = 6'd9;
   localparam logic [5:0] c_op_lui  = 6'd10;
   localparam logic [5:0] c_op_sltu = 6'd11;

   logic [31:0] r_imm;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic        r_wreg;
   logic        r_m2reg;
   logic        r_wmem;
   logic [5:0]  r_aluc;
   logic        r_aluimm;
   logic        r_shift;
   logic        r_branch;
   logic [31:0] r_pc4;
   logic [4:0]  r_destR;
   logic [3:0]  r_ins_type;
   logic [3:0]  r_ins_number;

   logic [31:0] w_alu_a;
   logic [31:0] w_alu_b;
   logic [31:0] w_alu_r;
   logic [4:0]  w_shamt;

   // Reset turns the in-flight instruction into a bubble (op 0 on zeros).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_imm        <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_wreg       <= 1'b0;
         r_m2reg      <= 1'b0;
         r_wmem       <= 1'b0;
         r_aluc       <= '0;
         r_aluimm     <= 1'b0;
         r_shift      <= 1'b0;
         r_branch     <= 1'b0;
         r_pc4        <= '0;
         r_destR      <= '0;
         r_ins_type   <= '0;
         r_ins_number <= '0;
      end else begin
         r_imm        <= id_imm;
         r_a          <= id_a_in;
         r_b          <= id_b_in;
         r_wreg       <= id_wreg;
         r_m2reg      <= id_m2reg;
         r_wmem       <= id_wmem;
         r_aluc       <= id_aluc;
         r_aluimm     <= id_aluimm;
         r_shift      <= id_shift;
         r_branch     <= id_branch;
         r_pc4        <= id_pc4;
         r_destR      <= id_destR;
         r_ins_type   <= ex_ins_type;
         r_ins_number <= ex_ins_number;
      end
   end

   assign w_alu_a = r_shift  ? {27'b0, r_imm[10:6]} : r_a;
   assign w_alu_b = r_aluimm ? r_imm : r_b;
   assign w_shamt = w_alu_a[4:0];

   always_comb begin
      w_alu_r = '0;
      case (r_aluc)
         c_op_add:  w_alu_r = w_alu_a + w_alu_b;
         c_op_sub:  w_alu_r = w_alu_a - w_alu_b;
         c_op_and:  w_alu_r = w_alu_a & w_alu_b;
         c_op_or:   w_alu_r = w_alu_a | w_alu_b;
         c_op_xor:  w_alu_r = w_alu_a ^ w_alu_b;
         c_op_nor:  w_alu_r = ~(w_alu_a | w_alu_b);
         c_op_slt:  w_alu_r = {31'b0, $signed(w_alu_a) < $signed(w_alu_b)};
         c_op_sll:  w_alu_r = w_alu_b << w_shamt;
         c_op_srl:  w_alu_r = w_alu_b >> w_shamt;
         c_op_sra:  w_alu_r = $unsigned($signed(w_alu_b) >>> w_shamt);
         c_op_lui:  w_alu_r = {w_alu_b[15:0], 16'b0};
         c_op_sltu: w_alu_r = {31'b0, w_alu_a < w_alu_b};
         default:   w_alu_r = '0;
      endcase
   end

   assign ex_aluR        = w_alu_r;
   assign ex_zero        = (w_alu_r == 32'b0);
   assign ex_pc          = r_pc4 + {r_imm[29:0], 2'b00};
   assign led            = r_branch & ex_zero;
   assign dbg            = {w_alu_a[15:0], w_alu_b[15:0]};

   assign ex_wreg        = r_wreg;
   assign ex_m2reg       = r_m2reg;
   assign ex_wmem        = r_wmem;
   assign ex_branch      = r_branch;
   assign ex_inB         = r_b;
   assign ex_destR       = r_destR;
   assign mem_ins_type   = r_ins_type;
   assign mem_ins_number = r_ins_number;

endmodule

`default_nettype wire

// File: tb/tb_pipe_execute_stage.sv
// ============================================================================
// Module   : tb_pipe_execute_stage
// Brief    : Scoreboard bench for pipe_execute_stage with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_execute_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] id_imm, id_a_in, id_b_in, id_pc4;
   logic        id_wreg, id_m2reg, id_wmem, id_aluimm, id_shift, id_branch;
   logic [5:0]  id_aluc;
   logic [4:0]  id_destR;
   logic [3:0]  ex_ins_type, ex_ins_number;
   logic        ex_wreg, ex_m2reg, ex_wmem, ex_branch, ex_zero, led;
   logic [31:0] ex_aluR, ex_inB, ex_pc, dbg;
   logic [4:0]  ex_destR;
   logic [3:0]  mem_ins_type, mem_ins_number;

   typedef struct {
      logic [31:0] alu, pc, dbg, inb;
      logic        zero, led, wreg, m2reg, wmem, branch;
      logic [4:0]  destr;
      logic [3:0]  t, n;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   bit   done = 1'b0;

   always #5 clk = ~clk;

   pipe_execute_stage dut (
      .clk(clk), .rst(rst),
      .id_imm(id_imm), .id_a_in(id_a_in), .id_b_in(id_b_in),
      .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem),
      .id_aluc(id_aluc), .id_aluimm(id_aluimm), .id_shift(id_shift),
      .id_branch(id_branch), .id_pc4(id_pc4), .id_destR(id_destR),
      .ex_ins_type(ex_ins_type), .ex_ins_number(ex_ins_number),
      .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
      .ex_branch(ex_branch), .ex_aluR(ex_aluR), .ex_inB(ex_inB),
      .ex_destR(ex_destR), .ex_pc(ex_pc), .ex_zero(ex_zero),
      .mem_ins_type(mem_ins_type), .mem_ins_number(mem_ins_number),
      .led(led), .dbg(dbg)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // Drive one instruction at the falling edge and queue its expected result.
   task automatic vec(input logic r, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] imm, input logic [31:0] pc4, input logic [5:0] aluc,
                      input logic aluimm, input logic shift, input logic wreg,
                      input logic m2reg, input logic wmem, input logic branch,
                      input logic [4:0] destr, input logic [3:0] t, input logic [3:0] n,
                      input logic [31:0] e_alu, input logic [31:0] e_pc,
                      input logic [31:0] e_dbg);
      exp_t e;
      @(negedge clk);
      rst = r; id_a_in = a; id_b_in = b; id_imm = imm; id_pc4 = pc4;
      id_aluc = aluc; id_aluimm = aluimm; id_shift = shift;
      id_wreg = wreg; id_m2reg = m2reg; id_wmem = wmem; id_branch = branch;
      id_destR = destr; ex_ins_type = t; ex_ins_number = n;
      if (r) begin
         e.alu = 0; e.pc = 0; e.dbg = 0; e.inb = 0; e.zero = 1'b1; e.led = 1'b0;
         e.wreg = 0; e.m2reg = 0; e.wmem = 0; e.branch = 0; e.destr = 0; e.t = 0; e.n = 0;
      end else begin
         e.alu = e_alu; e.pc = e_pc; e.dbg = e_dbg; e.inb = b;
         e.zero = (e_alu == 32'd0); e.led = branch & (e_alu == 32'd0);
         e.wreg = wreg; e.m2reg = m2reg; e.wmem = wmem; e.branch = branch;
         e.destr = destr; e.t = t; e.n = n;
      end
      q.push_back(e);
   endtask

   // Monitor: one result per capturing edge, sampled just after it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("aluR",   ex_aluR,  e.alu);
            chk("zero",   {31'b0, ex_zero},  {31'b0, e.zero});
            chk("pc",     ex_pc,    e.pc);
            chk("led",    {31'b0, led},      {31'b0, e.led});
            chk("dbg",    dbg,      e.dbg);
            chk("inB",    ex_inB,   e.inb);
            chk("ctrl",   {28'b0, ex_wreg, ex_m2reg, ex_wmem, ex_branch},
                          {28'b0, e.wreg, e.m2reg, e.wmem, e.branch});
            chk("destR",  {27'b0, ex_destR}, {27'b0, e.destr});
            chk("tags",   {24'b0, mem_ins_type, mem_ins_number}, {24'b0, e.t, e.n});
         end
      end
   end

   initial begin
      rst = 1'b1;
      id_imm = 0; id_a_in = 0; id_b_in = 0; id_pc4 = 0; id_aluc = 0;
      id_aluimm = 0; id_shift = 0; id_wreg = 0; id_m2reg = 0; id_wmem = 0;
      id_branch = 0; id_destR = 0; ex_ins_type = 0; ex_ins_number = 0;
      //   rst a            b            imm          pc4        aluc ai sh wr m2 wm br dst t  n   alu          pc           dbg
      vec(1, 32'd5,       32'd9,       32'd1,       32'h40,    6'd0,  1, 0, 1, 1, 1, 1, 5'd3, 4'd2, 4'd1, 0, 0, 0);
      vec(0, 32'd5,       32'd0,       32'hFFFFFFFF, 32'd0,    6'd0,  1, 0, 0, 0, 0, 0, 5'd0, 4'd0, 4'd0, 32'd4, 32'hFFFFFFFC, 32'h0005FFFF);
      vec(0, 32'd7,       32'd7,       32'd3,       32'h100,   6'd1,  0, 0, 0, 0, 0, 1, 5'd0, 4'd1, 4'd2, 32'd0, 32'h10C, 32'h00070007);
      vec(0, 32'd0,       32'h80000000, 32'h100,    32'd0,     6'd7,  0, 1, 0, 0, 0, 0, 5'd0, 4'd0, 4'd0, 32'd0, 32'h400, 32'h00040000);
      vec(0, 32'd0,       32'h80000000, 32'h100,    32'd0,     6'd8,  0, 1, 0, 0, 0, 0, 5'd0, 4'd0, 4'd0, 32'h08000000, 32'h400, 32'h00040000);
      vec(0, 32'd0,       32'h80000000, 32'h100,    32'd0,     6'd9,  0, 1, 0, 0, 0, 0, 5'd0, 4'd0, 4'd0, 32'hF8000000, 32'h400, 32'h00040000);
      vec(0, 32'hFFFFFFFF, 32'd1,      32'd0,       32'd0,     6'd6,  0, 0, 0, 0, 0, 0, 5'd0, 4'd0, 4'd0, 32'd1, 32'd0, 32'hFFFF0001);
      vec(0, 32'hFFFFFFFF, 32'd1,      32'd0,       32'd0,     6'd11, 0, 0, 0, 0, 0, 0, 5'd0, 4'd0, 4'd0, 32'd0, 32'd0, 32'hFFFF0001);
      vec(0, 32'd0,       32'd0,       32'h1234,    32'd0,     6'd10, 1, 0, 0, 0, 0, 0, 5'd0, 4'd0, 4'd0, 32'h12340000, 32'h48D0, 32'h00001234);
      vec(0, 32'd0,       32'hDEADBEEF, 32'd0,      32'd0,     6'd0,  0, 0, 1, 1, 0, 0, 5'd17, 4'd3, 4'd9, 32'hDEADBEEF, 32'd0, 32'h0000BEEF);
      vec(0, 32'hF0,      32'h0F,      32'd0,       32'h20,    6'd3,  0, 0, 0, 0, 1, 1, 5'd4, 4'd5, 4'd6, 32'hFF, 32'h20, 32'h00F0000F);
      vec(0, 32'hFF00FF00, 32'h0FF00FF0, 32'd0,     32'd0,     6'd2,  0, 0, 0, 0, 0, 0, 5'd0, 4'd0, 4'd0, 32'h0F000F00, 32'd0, 32'hFF000FF0);
      vec(0, 32'hFF00FF00, 32'h0FF00FF0, 32'd0,     32'd0,     6'd4,  0, 0, 0, 0, 0, 0, 5'd0, 4'd0, 4'd0, 32'hF0F0F0F0, 32'd0, 32'hFF000FF0);
      vec(0, 32'hFF00FF00, 32'h0FF00FF0, 32'd0,     32'd0,     6'd5,  0, 0, 0, 0, 0, 0, 5'd0, 4'd0, 4'd0, 32'h000F000F, 32'd0, 32'hFF000FF0);
      vec(0, 32'd0,       32'd1,       32'd0,       32'd0,     6'd1,  0, 0, 0, 0, 0, 0, 5'd0, 4'd0, 4'd0, 32'hFFFFFFFF, 32'd0, 32'h00000001);
      vec(0, 32'd3,       32'd5,       32'd0,       32'd0,     6'd12, 0, 0, 0, 0, 0, 1, 5'd0, 4'd0, 4'd0, 32'd0, 32'd0, 32'h00030005);
      vec(0, 32'd3,       32'd5,       32'd0,       32'd8,     6'd63, 0, 0, 1, 0, 0, 0, 5'd2, 4'd7, 4'd8, 32'd0, 32'd8, 32'h00030005);
      vec(1, 32'd3,       32'd5,       32'd2,       32'd8,     6'd4,  0, 0, 1, 1, 1, 1, 5'd9, 4'd1, 4'd1, 0, 0, 0);
      vec(0, 32'd2,       32'd3,       32'd0,       32'd0,     6'd0,  0, 0, 1, 0, 0, 0, 5'd1, 4'd2, 4'd2, 32'd5, 32'd0, 32'h00020003);
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipe_execute_stage.md
# pipe_execute_stage

Execute stage of the 5-stage MIPS-style pipeline, between the decode stage and the memory stage. It contains the ID/EX pipeline register, which captures decode outputs on each pipeline clock. It then computes the ALU result, zero flag and branch target combinationally from the registered values. It also forwards the memory and write-back control bits, the store data, the destination register and the per-stage debug instruction tags.

## Interface
Parameters: none.

Ports:
- clk  in  1  pipeline step clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- id_imm  in  32  sign-extended immediate; bits [10:6] are the shift amount.
- id_a_in  in  32  forwarded operand A.
- id_b_in  in  32  forwarded operand B; also the store data.
- id_wreg, id_m2reg, id_wmem  in  1 each  register-write, load-select and memory-write controls.
- id_aluc  in  6  ALU operation code.
- id_aluimm  in  1  1 selects the immediate as ALU B.
- id_shift  in  1  1 selects the shift amount as ALU A.
- id_branch  in  1  branch flag, passed through.
- id_pc4  in  32  PC+4 of the instruction.
- id_destR  in  5  destination register number.
- ex_ins_type, ex_ins_number  in  4 each  debug tags of the instruction entering EX.
- ex_wreg, ex_m2reg, ex_wmem, ex_branch  out  1 each  registered controls.
- ex_aluR  out  32  ALU result.
- ex_inB  out  32  registered id_b_in (store data).
- ex_destR  out  5  registered destination.
- ex_pc  out  32  branch target.
- ex_zero  out  1  1 when ex_aluR == 0.
- mem_ins_type, mem_ins_number  out  4 each  registered debug tags.
- led  out  1  ex_branch & ex_zero.
- dbg  out  32  {ALU A[15:0], ALU B[15:0]}.

## Operation
- ID/EX register: on each rising clk edge, capture every id_* input and ex_ins_type/ex_ins_number.
- Operand select:
  - A = id_shift ? {27'b0, imm[10:6]} : a.
  - B = id_aluimm ? imm : b.
- ALU on id_aluc. All arithmetic is 32-bit and wraps modulo 2^32 with no overflow trap.
  - 0 add A+B
  - 1 sub A−B
  - 2 and
  - 3 or
  - 4 xor
  - 5 nor
  - 6 slt: signed compare, result 1 or 0
  - 7 sll: B << A[4:0]
  - 8 srl: B >> A[4:0] logical
  - 9 sra: arithmetic
  - 10 lui: {B[15:0], 16'b0}
  - 11 sltu: unsigned compare
  - all other codes: result 0.
- ex_zero = (ex_aluR == 32'b0).
- ex_pc = registered pc4 + (registered imm << 2), 32-bit wrap.
- All other outputs are registered fields passed straight through.

## Timing
- Latency: ex_aluR, ex_zero, ex_pc, led and dbg are valid combinationally in the cycle after the capturing edge (one-cycle latency from id_*).
- Reset: if rst is high at a rising edge, every registered field clears to 0 and the capture is skipped. Resulting outputs:
  - all controls = 0, ex_destR = 0, ex_inB = 0, tags = 0.
  - ALU state: op 0 on A = B = 0, so ex_aluR = 0, ex_zero = 1, ex_pc = 0, led = 0, dbg = 0.
- A reset in the middle of a stream discards the in-flight instruction (it becomes a bubble).
- No stall or flush input: the stage captures on every edge. Bubbles arrive from decode as all-zero controls.
- Power-up before the first reset: register contents are undefined.
- No handshake.

## Test plan
- Reset: assert rst for one edge → all outputs 0 except ex_zero = 1.
- Add immediate: a = 5, imm = 0xFFFFFFFF, aluimm = 1, aluc = 0, then clock → ex_aluR = 4, ex_zero = 0.
- Zero and branch target: a = b = 7, aluc = 1, branch = 1, pc4 = 0x100, imm = 3 → ex_aluR = 0, ex_zero = 1, led = 1, ex_pc = 0x10C.
- Shifts: b = 0x80000000, imm[10:6] = 4, shift = 1 →
  - aluc 7 gives 0
  - aluc 8 gives 0x08000000
  - aluc 9 gives 0xF8000000.
- Compare and lui: a = 0xFFFFFFFF, b = 1 → aluc 6 gives 1, aluc 11 gives 0. imm = 0x1234 with aluc 10 → 0x12340000.
- Pass-through: wreg = 1, m2reg = 1, wmem = 0, destR = 17, b = 0xDEADBEEF, tags 3/9 → after one edge the same values appear on the ex_* outputs and mem_ins_type = 3, mem_ins_number = 9.
